// File: rtl/axi_line_adapter_pkg.sv
// Shared AXI definitions for the line adapter: request/response bundles,
// FSM state encodings and AXI burst/size constants.
package axi_line_adapter_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_AW   = 3'd3;
    localparam logic [2:0] S_W    = 3'd4;
    localparam logic [2:0] S_B    = 3'd5;

    localparam logic [1:0] INCR    = 2'b01;
    localparam logic [2:0] SIZE_4B = 3'b010;

    typedef struct packed {
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        arlock;
        logic [3:0]  arcache;
        logic [2:0]  arprot;
        logic        arvalid;
        logic        rready;
        logic [31:0] awaddr;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        awlock;
        logic [3:0]  awcache;
        logic [2:0]  awprot;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        wvalid;
        logic        bready;
    } axi_req_t;

    typedef struct packed {
        logic        arready;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
        logic        rvalid;
        logic        awready;
        logic        wready;
        logic [1:0]  bresp;
        logic        bvalid;
    } axi_resp_t;

endpackage

// File: rtl/axi_line_adapter.sv
// Cache-line to AXI4 burst adapter: one outstanding line read or write,
// writes served before reads when both are requested in IDLE.
// Ports: clk, rst (sync, active high); rd_req/rd_addr -> rd_valid/rd_line;
// wr_req/wr_addr/wr_line -> wr_done; busy; axi_req/axi_resp master bundle;
// err (sticky response error) only when AXI_LINE_ERR_EN is defined.
module axi_line_adapter
    import axi_line_adapter_pkg::*;
#(
    parameter int LINE_WORDS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_req,
    input  logic [31:0]             rd_addr,
    output logic                    rd_valid,
    output logic [32*LINE_WORDS-1:0] rd_line,
    input  logic                    wr_req,
    input  logic [31:0]             wr_addr,
    input  logic [32*LINE_WORDS-1:0] wr_line,
    output logic                    wr_done,
    output logic                    busy,
    output axi_req_t                axi_req,
    input  axi_resp_t               axi_resp
`ifdef AXI_LINE_ERR_EN
    ,
    output logic                    err
`endif
);

    localparam int CW = $clog2(LINE_WORDS) + 1;
    localparam int IW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int OB = $clog2(LINE_WORDS * 4);
    localparam logic [31:0]   AMASK = ~((32'd1 << OB) - 32'd1);
    localparam logic [CW-1:0] LAST  = CW'(LINE_WORDS - 1);

    logic [2:0]                    state;
    logic [CW-1:0]                 cnt;
    logic [IW-1:0]                 widx;
    logic [31:0]                   addr;
    logic [LINE_WORDS-1:0][31:0]   line_q;
    logic [LINE_WORDS-1:0][31:0]   wbuf;
    logic                          beat_last;
    logic                          ar_hs;
    logic                          r_hs;
    logic                          aw_hs;
    logic                          w_hs;
    logic                          b_hs;

    assign widx      = cnt[IW-1:0];
    assign beat_last = (cnt == LAST);
    assign ar_hs     = axi_req.arvalid & axi_resp.arready;
    assign r_hs      = axi_req.rready  & axi_resp.rvalid;
    assign aw_hs     = axi_req.awvalid & axi_resp.awready;
    assign w_hs      = axi_req.wvalid  & axi_resp.wready;
    assign b_hs      = axi_req.bready  & axi_resp.bvalid;
    assign rd_line   = line_q;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            addr     <= '0;
            line_q   <= '0;
            wbuf     <= '0;
            rd_valid <= 1'b0;
            wr_done  <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            wr_done  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (wr_req) begin
                        addr  <= wr_addr;
                        wbuf  <= wr_line;
                        state <= S_AW;
                    end else if (rd_req) begin
                        addr  <= rd_addr;
                        state <= S_AR;
                    end
                end
                S_AR: begin
                    if (ar_hs) begin
                        cnt   <= '0;
                        state <= S_R;
                    end
                end
                S_R: begin
                    // completion is counted, rlast is not trusted
                    if (r_hs) begin
                        line_q[widx] <= axi_resp.rdata;
                        cnt          <= cnt + 1'b1;
                        if (beat_last) begin
                            rd_valid <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end
                end
                S_AW: begin
                    if (aw_hs) begin
                        cnt   <= '0;
                        state <= S_W;
                    end
                end
                S_W: begin
                    if (w_hs) begin
                        cnt <= cnt + 1'b1;
                        if (beat_last) state <= S_B;
                    end
                end
                S_B: begin
                    if (b_hs) begin
                        wr_done <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        axi_req         = '0;
        axi_req.araddr  = addr & AMASK;
        axi_req.arlen   = 8'(LINE_WORDS - 1);
        axi_req.arsize  = SIZE_4B;
        axi_req.arburst = INCR;
        axi_req.arvalid = (state == S_AR);
        axi_req.rready  = (state == S_R);
        axi_req.awaddr  = addr & AMASK;
        axi_req.awlen   = 8'(LINE_WORDS - 1);
        axi_req.awsize  = SIZE_4B;
        axi_req.awburst = INCR;
        axi_req.awvalid = (state == S_AW);
        axi_req.wdata   = wbuf[widx];
        axi_req.wstrb   = 4'hF;
        axi_req.wlast   = beat_last;
        axi_req.wvalid  = (state == S_W);
        axi_req.bready  = (state == S_B);
    end

`ifdef AXI_LINE_ERR_EN
    logic r_bad;
    logic b_bad;

    // rlast must coincide with the counted final beat
    assign r_bad = r_hs & ((axi_resp.rresp != 2'b00) |
                           (axi_resp.rlast != beat_last));
    assign b_bad = b_hs & (axi_resp.bresp != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (r_bad | b_bad) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_resp;
    assign unused_resp = ^{axi_resp.rresp, axi_resp.rlast, axi_resp.bresp};
`endif

endmodule

// File: tb/tb_axi_line_adapter.sv
// Testbench for axi_line_adapter: LINE_WORDS=8 and LINE_WORDS=4 instances
// driven by small AXI slave models, checked against expectation queues.
module tb_axi_line_adapter;
    import axi_line_adapter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A: LINE_WORDS = 8
    logic         a_rd_req = 1'b0;
    logic [31:0]  a_rd_addr = '0;
    logic         a_rd_valid;
    logic [255:0] a_rd_line;
    logic         a_wr_req = 1'b0;
    logic [31:0]  a_wr_addr = '0;
    logic [255:0] a_wr_line = '0;
    logic         a_wr_done;
    logic         a_busy;
    axi_req_t     a_req;
    axi_resp_t    a_resp;
    // instance B: LINE_WORDS = 4
    logic         b_rd_valid;
    logic [127:0] b_rd_line;
    logic         b_wr_req = 1'b0;
    logic [31:0]  b_wr_addr = '0;
    logic [127:0] b_wr_line = '0;
    logic         b_wr_done;
    logic         b_busy;
    axi_req_t     b_req;
    axi_resp_t    b_resp;
`ifdef AXI_LINE_ERR_EN
    logic         a_err;
    logic         b_err;
`endif

    axi_line_adapter #(.LINE_WORDS(8)) u_a (
        .clk(clk), .rst(rst),
        .rd_req(a_rd_req), .rd_addr(a_rd_addr),
        .rd_valid(a_rd_valid), .rd_line(a_rd_line),
        .wr_req(a_wr_req), .wr_addr(a_wr_addr), .wr_line(a_wr_line),
        .wr_done(a_wr_done), .busy(a_busy),
        .axi_req(a_req), .axi_resp(a_resp)
`ifdef AXI_LINE_ERR_EN
        , .err(a_err)
`endif
    );

    axi_line_adapter #(.LINE_WORDS(4)) u_b (
        .clk(clk), .rst(rst),
        .rd_req(1'b0), .rd_addr(32'h0),
        .rd_valid(b_rd_valid), .rd_line(b_rd_line),
        .wr_req(b_wr_req), .wr_addr(b_wr_addr), .wr_line(b_wr_line),
        .wr_done(b_wr_done), .busy(b_busy),
        .axi_req(b_req), .axi_resp(b_resp)
`ifdef AXI_LINE_ERR_EN
        , .err(b_err)
`endif
    );

    // slave models
    logic [31:0] a_rbase = '0;
    int          a_rbeat;
    logic        a_bpend, a_wtgl;
    logic        a_rlast_bad = 1'b0;
    logic [1:0]  a_bresp = 2'b00;
    int          b_rbeat;
    logic        b_bpend, b_wtgl;
    logic        b_wtoggle = 1'b0;

    always_comb begin
        a_resp         = '0;
        a_resp.arready = 1'b1;
        a_resp.awready = 1'b1;
        a_resp.rvalid  = 1'b1;
        a_resp.rdata   = a_rbase + 32'(a_rbeat);
        a_resp.rlast   = (a_rbeat == 7) || (a_rlast_bad && a_rbeat == 4);
        a_resp.wready  = 1'b1;
        a_resp.bvalid  = a_bpend;
        a_resp.bresp   = a_bresp;
    end

    always_comb begin
        b_resp         = '0;
        b_resp.arready = 1'b1;
        b_resp.awready = 1'b1;
        b_resp.rvalid  = 1'b1;
        b_resp.rdata   = 32'(b_rbeat);
        b_resp.rlast   = (b_rbeat == 3);
        b_resp.wready  = b_wtoggle ? b_wtgl : 1'b1;
        b_resp.bvalid  = b_bpend;
    end

    always @(posedge clk) begin
        if (rst) begin
            a_rbeat <= 0; a_bpend <= 1'b0; a_wtgl <= 1'b0;
            b_rbeat <= 0; b_bpend <= 1'b0; b_wtgl <= 1'b0;
        end else begin
            a_wtgl <= ~a_wtgl;
            b_wtgl <= ~b_wtgl;
            if (a_req.arvalid) a_rbeat <= 0;
            else if (a_req.rready) a_rbeat <= a_rbeat + 1;
            if (b_req.arvalid) b_rbeat <= 0;
            else if (b_req.rready) b_rbeat <= b_rbeat + 1;
            if (a_req.wvalid && a_resp.wready && a_req.wlast) a_bpend <= 1'b1;
            else if (a_req.bready && a_bpend) a_bpend <= 1'b0;
            if (b_req.wvalid && b_resp.wready && b_req.wlast) b_bpend <= 1'b1;
            else if (b_req.bready && b_bpend) b_bpend <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboards and monitors
    logic [255:0] a_rq[$];
    logic [32:0]  a_wq[$];
    logic [32:0]  b_wq[$];
    int           a_ev[$];
    int           a_rdv_cnt = 0, a_wrd_cnt = 0, b_wrd_cnt = 0;
    int           a_ar_cyc = 0, a_rdv_cyc = 0;
    logic [31:0]  a_araddr = '0, b_awaddr = '0;
    logic [7:0]   a_arlen = '0, b_awlen = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (a_req.arvalid) begin
                a_ev.push_back(2);
                a_ar_cyc = cyc;
                a_araddr = a_req.araddr;
                a_arlen  = a_req.arlen;
                chk("a_arsize_burst", 256'({a_req.arsize, a_req.arburst}),
                    256'({SIZE_4B, INCR}));
            end
            if (a_req.awvalid) a_ev.push_back(1);
            if (a_wr_done) begin
                a_ev.push_back(3);
                a_wrd_cnt++;
            end
            if (a_req.wvalid && a_resp.wready) begin
                if (a_wq.size() == 0) chk("a_w_unexp", 256'(a_wq.size()), 256'd1);
                else chk("a_wbeat", 256'({a_req.wlast, a_req.wdata}), 256'(a_wq.pop_front()));
            end
            if (a_rd_valid) begin
                a_rdv_cnt++;
                a_rdv_cyc = cyc;
                if (a_rq.size() == 0) chk("a_rdv_unexp", 256'(a_rq.size()), 256'd1);
                else chk("a_rd_line", a_rd_line, a_rq.pop_front());
            end
            if (b_req.awvalid) begin
                b_awaddr = b_req.awaddr;
                b_awlen  = b_req.awlen;
            end
            if (b_wr_done) b_wrd_cnt++;
            if (b_req.wvalid && b_resp.wready) begin
                chk("b_wstrb", 256'(b_req.wstrb), 256'hF);
                if (b_wq.size() == 0) chk("b_w_unexp", 256'(b_wq.size()), 256'd1);
                else chk("b_wbeat", 256'({b_req.wlast, b_req.wdata}), 256'(b_wq.pop_front()));
            end
        end
    end

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic a_read(input logic [31:0] addr, input logic [31:0] base);
        logic [255:0] line;
        int n0;
        for (int i = 0; i < 8; i++) line[32*i +: 32] = base + 32'(i);
        a_rq.push_back(line);
        a_rbase   = base;
        a_rd_addr = addr;
        n0        = a_rdv_cnt;
        a_rd_req  = 1'b1;
        step();
        a_rd_req  = 1'b0;
        for (int i = 0; i < 40 && a_rdv_cnt == n0; i++) step();
        chk("a_read_done", 256'(a_rdv_cnt), 256'(n0 + 1));
    endtask

    task automatic a_write(input logic [31:0] addr, input logic [31:0] base);
        int n0;
        for (int i = 0; i < 8; i++) begin
            a_wr_line[32*i +: 32] = base + 32'(i);
            a_wq.push_back({(i == 7), base + 32'(i)});
        end
        a_wr_addr = addr;
        n0        = a_wrd_cnt;
        a_wr_req  = 1'b1;
        step();
        a_wr_req  = 1'b0;
        for (int i = 0; i < 40 && a_wrd_cnt == n0; i++) step();
        chk("a_write_done", 256'(a_wrd_cnt), 256'(n0 + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [255:0] held;
        int n0;
        int ord;

        // reset state
        rst = 1'b1;
        repeat (3) step();
        chk("rst_a_busy", 256'(a_busy), 256'd0);
        chk("rst_a_axi_vr", 256'({a_req.arvalid, a_req.rready, a_req.awvalid,
            a_req.wvalid, a_req.bready}), 256'd0);
        chk("rst_a_pulses", 256'({a_rd_valid, a_wr_done}), 256'd0);
        chk("rst_a_rd_line", a_rd_line, 256'd0);
        chk("rst_b_busy", 256'(b_busy), 256'd0);
`ifdef AXI_LINE_ERR_EN
        chk("rst_err", 256'({a_err, b_err}), 256'd0);
`endif
        rst = 1'b0;
        step();

        // zero-wait 8-beat read returning 0..7
        a_rd_addr = 32'h1FC0_0014;
        a_read(32'h1FC0_0014, 32'h0);
        chk("rd_araddr", 256'(a_araddr), 256'h1FC0_0000);
        chk("rd_arlen", 256'(a_arlen), 256'd7);
        chk("rd_latency", 256'(a_rdv_cyc - a_ar_cyc), 256'd9);
        n0 = a_rdv_cnt;
        step();
        chk("rd_pulse_len", 256'({a_rd_valid, a_busy}), 256'd0);
        chk("rd_pulse_cnt", 256'(a_rdv_cnt), 256'(n0));

        // 4-word write with wready toggling
        b_wtoggle = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_wr_line[32*i +: 32] = 32'hA + 32'(i);
            b_wq.push_back({(i == 3), 32'hA + 32'(i)});
        end
        b_wr_addr = 32'h0000_1238;
        n0 = b_wrd_cnt;
        b_wr_req = 1'b1;
        step();
        b_wr_req = 1'b0;
        chk("wr_busy", 256'(b_busy), 256'd1);
        for (int i = 0; i < 40 && b_wrd_cnt == n0; i++) step();
        chk("wr_done_cnt", 256'(b_wrd_cnt), 256'(n0 + 1));
        chk("wr_awaddr", 256'(b_awaddr), 256'h0000_1230);
        chk("wr_awlen", 256'(b_awlen), 256'd3);
        chk("wr_beats_left", 256'(b_wq.size()), 256'd0);
        step();
        chk("wr_pulse_len", 256'(b_wr_done), 256'd0);
        chk("wr_pulse_cnt", 256'(b_wrd_cnt), 256'(n0 + 1));

        // simultaneous write and read: write first
        a_ev.delete();
        for (int i = 0; i < 8; i++) begin
            a_wr_line[32*i +: 32] = 32'h100 + 32'(i);
            a_wq.push_back({(i == 7), 32'h100 + 32'(i)});
            held[32*i +: 32] = 32'h50 + 32'(i);
        end
        a_rq.push_back(held);
        a_rbase   = 32'h50;
        a_wr_addr = 32'h0000_4000;
        a_rd_addr = 32'h0000_8000;
        n0 = a_rdv_cnt;
        a_wr_req = 1'b1;
        a_rd_req = 1'b1;
        step();
        a_wr_req = 1'b0;
        for (int i = 0; i < 60 && !a_req.arvalid; i++) step();
        chk("both_ar_seen", 256'(a_req.arvalid), 256'd1);
        a_rd_req = 1'b0;
        for (int i = 0; i < 40 && a_rdv_cnt == n0; i++) step();
        chk("both_rd_done", 256'(a_rdv_cnt), 256'(n0 + 1));
        ord = 0;
        foreach (a_ev[i]) ord = ord * 10 + a_ev[i];
        chk("both_order", 256'(ord), 256'd132);
        chk("both_araddr", 256'(a_araddr), 256'h0000_8000);

        // rd_line holds after completion
        repeat (5) step();
        chk("rd_line_hold", a_rd_line, held);

        // reset during R beat 3
        a_rbase   = 32'h70;
        a_rd_addr = 32'h0000_2000;
        a_rd_req  = 1'b1;
        step();
        a_rd_req  = 1'b0;
        for (int i = 0; i < 20 && a_rbeat != 3; i++) step();
        chk("mid_in_r", 256'({a_req.rready, 32'(a_rbeat)}), 256'({1'b1, 32'd3}));
        n0 = a_rdv_cnt;
        rst = 1'b1;
        step();
        chk("mid_rst_outs", 256'({a_busy, a_req.rready, a_rd_valid}), 256'd0);
        chk("mid_rst_line", a_rd_line, 256'd0);
        rst = 1'b0;
        repeat (12) step();
        chk("mid_no_rdv", 256'(a_rdv_cnt), 256'(n0));
        a_read(32'h0000_3004, 32'h90);
        chk("mid_araddr", 256'(a_araddr), 256'h0000_3000);

`ifdef AXI_LINE_ERR_EN
        // error reporting
        a_bresp = 2'b10;
        a_write(32'h0000_5000, 32'h200);
        a_bresp = 2'b00;
        chk("err_bresp", 256'(a_err), 256'd1);
        a_read(32'h0000_6000, 32'h300);
        chk("err_sticky", 256'(a_err), 256'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("err_cleared", 256'(a_err), 256'd0);
        a_rlast_bad = 1'b1;
        a_read(32'h0000_7000, 32'h400);
        a_rlast_bad = 1'b0;
        chk("err_rlast", 256'(a_err), 256'd1);
        chk("err_b_clean", 256'(b_err), 256'd0);
`endif

        chk("sb_a_rq_empty", 256'(a_rq.size()), 256'd0);
        chk("sb_a_wq_empty", 256'(a_wq.size()), 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_line_adapter.md
AXI_LINE_ADAPTER -- requirements
Module: axi_line_adapter

Interface
REQ-001 The module SHALL have parameter LINE_WORDS, default 8: number of 32-bit words per line; legal values 1, 2, 4, 8, 16.
REQ-002 The module SHALL have one clock and a synchronous, active-high reset, on ports clk and rst.
REQ-003 The ports SHALL be, clock and reset first:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rd_req  in  1  line read request.
- rd_addr  in  32  physical read address.
- rd_valid  out  1  one-cycle pulse: rd_line holds the completed line.
- rd_line  out  32*LINE_WORDS  read line; word i is at bits [32i+31:32i].
- wr_req  in  1  line write request.
- wr_addr  in  32  physical write address.
- wr_line  in  32*LINE_WORDS  write line data.
- wr_done  out  1  one-cycle pulse: write response received.
- busy  out  1  high when not in IDLE.
- axi_req  out  axi_req_t  AXI master request bundle.
- axi_resp  in  axi_resp_t  AXI slave response bundle.
- err  out  1  sticky response error; present only with AXI_LINE_ERR_EN.

Function
REQ-004 Requests SHALL be sampled only in IDLE; addresses and wr_line SHALL be captured on acceptance, so callers may drop the request on the next cycle.
REQ-005 When wr_req and rd_req are both high in IDLE, the write SHALL be served first; the read SHALL be accepted later only if rd_req is still high.
REQ-006 The states SHALL be IDLE, AR, R, AW, W, B. Transitions:
- IDLE->AW on wr_req; otherwise IDLE->AR on rd_req.
- AR->R on arvalid&arready.
- R->IDLE when the LINE_WORDS-th beat completes (rvalid&rready).
- AW->W on awvalid&awready.
- W->B when the last beat completes (wvalid&wready).
- B->IDLE on bvalid&bready.
REQ-007 Address fields SHALL be driven as follows:
- araddr/awaddr = captured address with low log2(LINE_WORDS*4) bits cleared.
- arlen/awlen = LINE_WORDS-1, arsize/awsize = 3'b010, arburst/awburst = 2'b01.
- arlock/awlock, arcache/awcache, arprot/awprot = 0.
REQ-008 Valid and ready signals SHALL follow state: arvalid=(AR), rready=(R), awvalid=(AW), wvalid=(W), bready=(B). Each valid SHALL stay high until its handshake completes.
REQ-009 A beat counter of width log2(LINE_WORDS)+1 SHALL reset to 0 on entry to R and to W, and SHALL increment on each beat handshake.
REQ-010 In R, rdata of beat k SHALL be stored into word k of rd_line.
REQ-011 In W, the write channel SHALL be driven as:
- wdata = captured word k, wstrb = 4'hF.
- wlast = 1 exactly when k == LINE_WORDS-1.
REQ-012 Read completion SHALL ignore rlast; completion is counter-based only.
REQ-013 rd_valid SHALL pulse for exactly one cycle, in the cycle after the last R beat handshake.
REQ-014 rd_line SHALL hold its value until the next read overwrites it.
REQ-015 wr_done SHALL pulse for exactly one cycle, in the cycle after the B handshake.
REQ-016 Only one transaction SHALL be outstanding; busy SHALL be high in every non-IDLE state, including the completion cycle.
REQ-017 Beats SHALL arrive back-to-back with zero idle cycles when the slave keeps valid/ready high.

Reset
REQ-018 When rst is high at a clock edge, the next state SHALL be IDLE and the counter 0.
REQ-019 In the cycle after such an edge, these outputs SHALL be 0: all AXI valid/ready outputs, rd_valid, wr_done, busy, err.
REQ-020 rd_line SHALL reset to 0.
REQ-021 Reset mid-burst SHALL abandon the transaction with no completion pulse; the interconnect is reset together with the module.

Configuration
REQ-022 The macro AXI_LINE_ERR_EN SHALL control error checking.
REQ-023 With AXI_LINE_ERR_EN defined:
- err SHALL set on any completed beat with rresp!=0 or bresp!=0, or with rlast mismatching the counter.
- err SHALL clear only on rst.
- Completion behaviour SHALL be unchanged.
REQ-024 Without AXI_LINE_ERR_EN, the err port and its logic SHALL be absent, and responses SHALL be ignored.

Structure
REQ-025 The state enum and the AXI burst/size constants (INCR = 2'b01, SIZE_4B = 3'b010) SHALL live in the shared common definitions header beside axi_req_t/axi_resp_t.
REQ-026 The module SHALL be flat; no sub-module is natural.

Verification
REQ-027 Read, LINE_WORDS=8: rd_addr=0x1FC0_0014 with a zero-wait slave returning 0..7.
-> araddr=0x1FC0_0000, arlen=7; rd_line word i = i; rd_valid pulses once, 9 cycles after arvalid&arready.
REQ-028 Write, LINE_WORDS=4: wr_addr=0x0000_1238, wr_line words 0xA..0xD, wready toggling every cycle.
-> awaddr=0x0000_1230, awlen=3; wdata sequence A,B,C,D; wlast only on D; wr_done pulses once, after bvalid.
REQ-029 rd_req and wr_req both high in the same IDLE cycle.
-> AW issued first; AR issued after wr_done while rd_req stays high.
REQ-030 rst asserted during R beat 3 of 8.
-> next cycle: IDLE, rready=0, busy=0, no rd_valid; a following read completes normally.
REQ-031 With AXI_LINE_ERR_EN, bresp=2'b10 on a write.
-> err=1 and wr_done still pulses; err stays 1 until rst.
-> Also: rlast asserted on beat 5 of 8 sets err, and the read still completes after 8 beats.
